// File: rtl/scan_mux_reg_pkg.sv
// Shared types, defaults and helpers for the scan_mux_reg sampler.
package mux_pkg;

  typedef enum logic [0:0] {MANUAL, SCAN} state_e;

  localparam int unsigned DefWidth    = 1;
  localparam int unsigned DefChannels = 4;
  localparam int unsigned DefDwellW   = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_mux_reg_if.sv
// Channel bus for scan_mux_reg: select controls and channel words in, registered sample out.
// Optional macro SCAN_MUX_INV_OUT_EN adds the inverted output y_n.
interface scan_mux_if import mux_pkg::*; #(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned DWELL_W  = DefDwellW
);
  localparam int unsigned SEL_W = clog2(CHANNELS);

  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [DWELL_W-1:0]        dwell;
  logic [CHANNELS*WIDTH-1:0] x;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          ch;
  logic                      y_valid;
  logic                      wrap;
`ifdef SCAN_MUX_INV_OUT_EN
  logic [WIDTH-1:0]          y_n;
`endif

  modport master (
    output en, mode, sel, dwell, x,
    input  y, ch, y_valid, wrap
`ifdef SCAN_MUX_INV_OUT_EN
    , input y_n
`endif
  );

  modport slave (
    input  en, mode, sel, dwell, x,
    output y, ch, y_valid, wrap
`ifdef SCAN_MUX_INV_OUT_EN
    , output y_n
`endif
  );

endinterface

// File: rtl/scan_mux_reg_scan_ctr.sv
// Scan pointer with dwell counter and wrap pulse generation.
module scan_ctr import mux_pkg::*; #(
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned DWELL_W  = DefDwellW
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        en,
  input  logic                        mode,
  input  logic [clog2(CHANNELS)-1:0]  load_sel,
  input  logic [DWELL_W-1:0]          dwell,
  output logic [clog2(CHANNELS)-1:0]  pointer,
  output logic                        wrap
);
  localparam int unsigned SEL_W = clog2(CHANNELS);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(CHANNELS - 1);

  logic [DWELL_W-1:0] count_q;
  logic [SEL_W-1:0]   ptr_q;
  logic               wrap_q;

  // Manual mode preloads the pointer; scan mode advances it after dwell+1 enabled edges.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (!en) begin
      wrap_q  <= 1'b0;
    end else if (!mode) begin
      count_q <= '0;
      ptr_q   <= load_sel;
      wrap_q  <= 1'b0;
    end else if (count_q >= dwell) begin
      // A counter already past a newly lowered dwell counts as expired.
      count_q <= '0;
      wrap_q  <= (ptr_q == LastCh);
      ptr_q   <= (ptr_q == LastCh) ? '0 : ptr_q + SEL_W'(1);
    end else begin
      count_q <= count_q + DWELL_W'(1);
      wrap_q  <= 1'b0;
    end
  end

  assign pointer = ptr_q;
  assign wrap    = wrap_q;

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N:1 channel sampler with manual or auto-scan selection.
// Optional macro SCAN_MUX_INV_OUT_EN adds y_n = ~y from the same register.
module scan_mux_reg import mux_pkg::*; #(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned DWELL_W  = DefDwellW
) (
  input logic       clk,
  input logic       clrn,
  scan_mux_if.slave bus
);
  localparam int unsigned SEL_W = clog2(CHANNELS);

  logic             sel_legal;
  logic [SEL_W-1:0] load_sel;
  logic [SEL_W-1:0] pointer;
  logic [WIDTH-1:0] man_word;
  logic [WIDTH-1:0] scan_word;
  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] y_q;
  logic [SEL_W-1:0] ch_q;
  logic             y_valid_q;

  assign sel_legal = 32'(bus.sel) < CHANNELS;
  // Illegal manual selections park the scan pointer on channel 0.
  assign load_sel  = sel_legal ? bus.sel : '0;
  assign state_d   = bus.en ? (bus.mode ? SCAN : MANUAL) : state_q;

  scan_ctr #(
    .CHANNELS (CHANNELS),
    .DWELL_W  (DWELL_W)
  ) u_scan_ctr (
    .clk      (clk),
    .clrn     (clrn),
    .en       (bus.en),
    .mode     (bus.mode),
    .load_sel (load_sel),
    .dwell    (bus.dwell),
    .pointer  (pointer),
    .wrap     (bus.wrap)
  );

  // Pick the manual and scan candidate words; out-of-range indices yield zero.
  always_comb begin
    man_word  = '0;
    scan_word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(bus.sel) == k) man_word  = bus.x[k*WIDTH +: WIDTH];
      if (32'(pointer) == k) scan_word = bus.x[k*WIDTH +: WIDTH];
    end
  end

  // State and output register; y_valid marks a fresh sample taken on an enabled edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= MANUAL;
      y_q       <= '0;
      ch_q      <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_valid_q <= 1'b0;
      if (bus.en) begin
        unique case (state_d)
          SCAN: begin
            y_q       <= scan_word;
            ch_q      <= pointer;
            y_valid_q <= 1'b1;
          end
          MANUAL: begin
            y_q       <= man_word;
            ch_q      <= bus.sel;
            y_valid_q <= sel_legal;
          end
        endcase
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.ch      = ch_q;
  assign bus.y_valid = y_valid_q;
`ifdef SCAN_MUX_INV_OUT_EN
  assign bus.y_n     = ~y_q;
`endif

endmodule

// File: tb/tb_scan_mux_reg.sv
// Self-checking bench for scan_mux_reg: a 4-channel and a 3-channel instance.
module tb_scan_mux_reg;
  logic clk = 1'b0;
  logic clrn;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] w4 [4];
  logic [3:0] w3 [3];

  scan_mux_if #(.WIDTH(4), .CHANNELS(4), .DWELL_W(8)) bus4 ();
  scan_mux_if #(.WIDTH(4), .CHANNELS(3), .DWELL_W(8)) bus3 ();

  scan_mux_reg #(.WIDTH(4), .CHANNELS(4), .DWELL_W(8)) dut4 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus4)
  );

  scan_mux_reg #(.WIDTH(4), .CHANNELS(3), .DWELL_W(8)) dut3 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus3)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    exp_t e;
    clrn = 1'b0;
    bus4.en = 1'b0; bus4.mode = 1'b0; bus4.sel = 2'd0; bus4.dwell = 8'd0;
    bus4.x = {4'hD, 4'hC, 4'hB, 4'hA};
    bus3.en = 1'b0; bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.dwell = 8'd0;
    bus3.x = {4'h9, 4'h6, 4'h3};
    #3;
    checks++;
    if (bus4.y !== 4'h0 || bus4.ch !== 2'd0 || bus4.y_valid !== 1'b0 || bus4.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset4: got y=%h ch=%0d v=%b w=%b, expected 0 0 0 0",
               bus4.y, bus4.ch, bus4.y_valid, bus4.wrap);
    end
    checks++;
    if (bus3.y !== 4'h0 || bus3.ch !== 2'd0 || bus3.y_valid !== 1'b0 || bus3.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset3: got y=%h ch=%0d v=%b w=%b, expected 0 0 0 0",
               bus3.y, bus3.ch, bus3.y_valid, bus3.wrap);
    end
`ifdef SCAN_MUX_INV_OUT_EN
    checks++;
    if (bus4.y_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_y_n: got %h, expected f", bus4.y_n);
    end
`endif
    @(negedge clk);
    clrn = 1'b1;
    // No update until an enabled edge arrives.
    bus4.sel = 2'd2;
    sb.push_back('{y: 4'h0, ch: 2'd0, v: 1'b0, w: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (bus4.y !== e.y || bus4.ch !== e.ch || bus4.y_valid !== e.v || bus4.wrap !== e.w) begin
      errors++;
      $display("FAIL reset_no_en: got y=%h ch=%0d v=%b w=%b, expected y=%h ch=%0d v=%b w=%b",
               bus4.y, bus4.ch, bus4.y_valid, bus4.wrap, e.y, e.ch, e.v, e.w);
    end
  endtask

  task automatic test_manual();
    exp_t e;
    int   sels [3] = '{2, 0, 3};
    bus4.en = 1'b1;
    bus4.mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus4.sel = 2'(sels[i]);
      sb.push_back('{y: w4[sels[i]], ch: 2'(sels[i]), v: 1'b1, w: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus4.y !== e.y || bus4.ch !== e.ch || bus4.y_valid !== e.v || bus4.wrap !== e.w) begin
        errors++;
        $display("FAIL manual[%0d]: got y=%h ch=%0d v=%b w=%b, expected y=%h ch=%0d v=%b w=%b",
                 i, bus4.y, bus4.ch, bus4.y_valid, bus4.wrap, e.y, e.ch, e.v, e.w);
      end
    end
    // Asynchronous clear mid-run, checked well before the next edge.
    #2;
    clrn = 1'b0;
    #1;
    checks++;
    if (bus4.y !== 4'h0 || bus4.y_valid !== 1'b0 || bus4.ch !== 2'd0) begin
      errors++;
      $display("FAIL async_clr: got y=%h ch=%0d v=%b, expected y=0 ch=0 v=0",
               bus4.y, bus4.ch, bus4.y_valid);
    end
`ifdef SCAN_MUX_INV_OUT_EN
    checks++;
    if (bus4.y_n !== 4'hF) begin
      errors++;
      $display("FAIL async_clr_y_n: got %h, expected f", bus4.y_n);
    end
`endif
    #1;
    clrn = 1'b1;
  endtask

  task automatic test_scan_dwell2();
    exp_t e;
    int   seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    bus4.en = 1'b1;
    bus4.mode = 1'b1;
    bus4.dwell = 8'd2;
    for (int i = 0; i < 13; i++) begin
      sb.push_back('{y: w4[seq[i]], ch: 2'(seq[i]), v: 1'b1, w: (i == 11)});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus4.y !== e.y || bus4.ch !== e.ch || bus4.y_valid !== e.v || bus4.wrap !== e.w) begin
        errors++;
        $display("FAIL scan_d2[%0d]: got y=%h ch=%0d v=%b w=%b, expected y=%h ch=%0d v=%b w=%b",
                 i, bus4.y, bus4.ch, bus4.y_valid, bus4.wrap, e.y, e.ch, e.v, e.w);
      end
`ifdef SCAN_MUX_INV_OUT_EN
      checks++;
      if (bus4.y_n !== ~e.y) begin
        errors++;
        $display("FAIL scan_d2_y_n[%0d]: got %h, expected %h", i, bus4.y_n, ~e.y);
      end
`endif
    end
  endtask

  task automatic test_scan_dwell0_freeze();
    exp_t e;
    // Step table: enable, expected channel, expected valid, expected wrap.
    logic ens [13] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int   chs [13] = '{0, 0, 1, 2, 3, 0, 1, 1, 1, 1, 2, 3, 0};
    logic vs  [13] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    logic ws  [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    bus4.dwell = 8'd0;
    bus4.sel = 2'd0;
    for (int i = 0; i < 13; i++) begin
      bus4.en = ens[i];
      bus4.mode = (i != 0);
      sb.push_back('{y: w4[chs[i]], ch: 2'(chs[i]), v: vs[i], w: ws[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus4.y !== e.y || bus4.ch !== e.ch || bus4.y_valid !== e.v || bus4.wrap !== e.w) begin
        errors++;
        $display("FAIL scan_d0[%0d]: got y=%h ch=%0d v=%b w=%b, expected y=%h ch=%0d v=%b w=%b",
                 i, bus4.y, bus4.ch, bus4.y_valid, bus4.wrap, e.y, e.ch, e.v, e.w);
      end
    end
    bus4.en = 1'b1;
  endtask

  task automatic test_channels3();
    exp_t e;
    logic modes [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    int   sels  [8] = '{3, 1, 2, 0, 0, 0, 0, 0};
    logic [3:0] ys [8];
    int   chs   [8] = '{3, 1, 2, 2, 0, 1, 2, 0};
    logic vs    [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    logic ws    [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    ys[0] = 4'h0;
    for (int i = 1; i < 8; i++) ys[i] = w3[chs[i]];
    bus4.en = 1'b0;
    bus3.en = 1'b1;
    bus3.dwell = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bus3.mode = modes[i];
      bus3.sel = 2'(sels[i]);
      sb.push_back('{y: ys[i], ch: 2'(chs[i]), v: vs[i], w: ws[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus3.y !== e.y || bus3.ch !== e.ch || bus3.y_valid !== e.v || bus3.wrap !== e.w) begin
        errors++;
        $display("FAIL ch3[%0d]: got y=%h ch=%0d v=%b w=%b, expected y=%h ch=%0d v=%b w=%b",
                 i, bus3.y, bus3.ch, bus3.y_valid, bus3.wrap, e.y, e.ch, e.v, e.w);
      end
    end
    bus3.en = 1'b0;
  endtask

  task automatic test_mode_switch();
    exp_t e;
    logic modes  [12] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int   sels   [12] = '{2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int   dwells [12] = '{2, 2, 2, 2, 2, 2, 5, 5, 5, 5, 1, 1};
    int   chs    [12] = '{2, 2, 2, 2, 3, 0, 1, 1, 1, 1, 1, 2};
    bus4.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus4.mode = modes[i];
      bus4.sel = 2'(sels[i]);
      bus4.dwell = 8'(dwells[i]);
      sb.push_back('{y: w4[chs[i]], ch: 2'(chs[i]), v: 1'b1, w: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus4.y !== e.y || bus4.ch !== e.ch || bus4.y_valid !== e.v || bus4.wrap !== e.w) begin
        errors++;
        $display("FAIL mode_sw[%0d]: got y=%h ch=%0d v=%b w=%b, expected y=%h ch=%0d v=%b w=%b",
                 i, bus4.y, bus4.ch, bus4.y_valid, bus4.wrap, e.y, e.ch, e.v, e.w);
      end
    end
  endtask

  initial begin
    w4[0] = 4'hA; w4[1] = 4'hB; w4[2] = 4'hC; w4[3] = 4'hD;
    w3[0] = 4'h3; w3[1] = 4'h6; w3[2] = 4'h9;
    test_reset();
    test_manual();
    test_scan_dwell2();
    test_scan_dwell0_freeze();
    test_channels3();
    test_mode_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
